// File: rtl/imm_gen_stage.sv
// Registered immediate-generator pipeline stage with a 2-entry skid buffer.
// Optional macro IMM_GEN_ILLEGAL_EN adds the out_illegal flag.
module imm_gen_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [PC_W-1:0] out_target,
  output logic [31:0]     out_instr,
`ifdef IMM_GEN_ILLEGAL_EN
  output logic            out_illegal,
`endif
  output logic [PC_W-1:0] out_pc
);

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic [PC_W-1:0] target;
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
`ifdef IMM_GEN_ILLEGAL_EN
    logic            illegal;
`endif
  } entry_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_c;
  fmt_e            fmt_c;
  entry_t          new_c;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];

  always_comb begin
    imm_c = '0;
    fmt_c = FMT_NONE;
    case (opcode)
      7'b0010011: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          // An RV32 shift with instr[25] set has no legal encoding.
          if (XLEN == 64) begin
            fmt_c = FMT_SHAMT;
            imm_c = {{(XLEN-6){1'b0}}, in_instr[25:20]};
          end else if (!in_instr[25]) begin
            fmt_c = FMT_SHAMT;
            imm_c = {{(XLEN-5){1'b0}}, in_instr[24:20]};
          end
        end else begin
          fmt_c = FMT_I;
          imm_c = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
        end
      end
      7'b0000011, 7'b1100111: begin
        fmt_c = FMT_I;
        imm_c = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
      end
      7'b0100011: begin
        fmt_c = FMT_S;
        imm_c = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        fmt_c = FMT_B;
        imm_c = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25],
                 in_instr[11:8], 1'b0};
      end
      7'b1101111: begin
        fmt_c = FMT_J;
        imm_c = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20],
                 in_instr[30:21], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        fmt_c = FMT_U;
        imm_c = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
      end
      default: begin
        imm_c = '0;
        fmt_c = FMT_NONE;
      end
    endcase
  end

  always_comb begin
    new_c        = '0;
    new_c.imm    = imm_c;
    new_c.fmt    = fmt_c;
    new_c.target = in_pc + PC_W'(imm_c);
    new_c.instr  = in_instr;
    new_c.pc     = in_pc;
`ifdef IMM_GEN_ILLEGAL_EN
    // Only R-type legitimately decodes to NONE; everything else landing there is illegal.
    new_c.illegal = (in_instr[1:0] != 2'b11) ||
                    ((fmt_c == FMT_NONE) && (opcode != 7'b0110011));
`endif
  end

  entry_t main_q, main_d, skid_q, skid_d;
  logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic   accept, drain;

  assign accept = in_valid && !skid_valid_q;
  assign drain  = main_valid_q && out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain) begin
      // Skid is older than any new input, so it always wins the refill.
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d = new_c;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q) begin
        main_d       = new_c;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = new_c;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign in_ready   = !skid_valid_q;
  assign out_valid  = main_valid_q;
  assign out_imm    = main_q.imm;
  assign out_fmt    = main_q.fmt;
  assign out_target = main_q.target;
  assign out_instr  = main_q.instr;
  assign out_pc     = main_q.pc;
`ifdef IMM_GEN_ILLEGAL_EN
  assign out_illegal = main_q.illegal;
`endif

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage: XLEN=32 and XLEN=64 instances,
// directed vectors, backpressure, flush and async reset.
module tb_imm_gen_stage;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [31:0] target;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic [31:0] out_target;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_illegal;

  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic [31:0] w_in_instr = '0;
  logic [31:0] w_in_pc = '0;
  logic        w_out_valid;
  logic        w_out_ready = 1'b1;
  logic [63:0] w_out_imm;
  logic [2:0]  w_out_fmt;
  logic [31:0] w_out_target;
  logic [31:0] w_out_instr;
  logic [31:0] w_out_pc;
  logic        w_out_illegal;

  int checks = 0;
  int errors = 0;
  exp_t q32[$];
  exp_t q64[$];

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .PC_W(32)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_target(out_target), .out_instr(out_instr),
`ifdef IMM_GEN_ILLEGAL_EN
    .out_illegal(out_illegal),
`endif
    .out_pc(out_pc)
  );

  imm_gen_stage #(.XLEN(64), .PC_W(32)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_instr(w_in_instr), .in_pc(w_in_pc),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_imm(w_out_imm), .out_fmt(w_out_fmt),
    .out_target(w_out_target), .out_instr(w_out_instr),
`ifdef IMM_GEN_ILLEGAL_EN
    .out_illegal(w_out_illegal),
`endif
    .out_pc(w_out_pc)
  );

`ifndef IMM_GEN_ILLEGAL_EN
  assign out_illegal   = 1'b0;
  assign w_out_illegal = 1'b0;
`endif

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Called at posedge+1; pushes the expectation the moment the handshake is committed.
  task automatic applyStimulus(input bit is64, input logic [31:0] instr, input logic [31:0] pc,
                               input logic [63:0] imm, input logic [2:0] fmt,
                               input logic [31:0] target, input logic ill);
    exp_t e;
    int guard = 0;
    while (((is64 ? w_in_ready : in_ready) == 1'b0) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if ((is64 ? w_in_ready : in_ready) == 1'b0) begin
      checkOutput("in_ready timeout", 64'(0), 64'(1));
    end else begin
      e.imm = imm; e.fmt = fmt; e.target = target; e.instr = instr; e.pc = pc; e.ill = ill;
      if (is64) begin
        w_in_valid = 1'b1; w_in_instr = instr; w_in_pc = pc; q64.push_back(e);
      end else begin
        in_valid = 1'b1; in_instr = instr; in_pc = pc; q32.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      w_in_valid = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL x32 unexpected output: got instr %h, required none", out_instr);
      end else begin
        e = q32.pop_front();
        checkOutput("x32 instr", 64'(out_instr), 64'(e.instr));
        checkOutput("x32 imm", 64'(out_imm), e.imm);
        checkOutput("x32 fmt", 64'(out_fmt), 64'(e.fmt));
        checkOutput("x32 target", 64'(out_target), 64'(e.target));
        checkOutput("x32 pc", 64'(out_pc), 64'(e.pc));
`ifdef IMM_GEN_ILLEGAL_EN
        checkOutput("x32 illegal", 64'(out_illegal), 64'(e.ill));
`endif
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && w_out_valid && w_out_ready) begin
      if (q64.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL x64 unexpected output: got instr %h, required none", w_out_instr);
      end else begin
        e = q64.pop_front();
        checkOutput("x64 instr", 64'(w_out_instr), 64'(e.instr));
        checkOutput("x64 imm", w_out_imm, e.imm);
        checkOutput("x64 fmt", 64'(w_out_fmt), 64'(e.fmt));
        checkOutput("x64 target", 64'(w_out_target), 64'(e.target));
`ifdef IMM_GEN_ILLEGAL_EN
        checkOutput("x64 illegal", 64'(w_out_illegal), 64'(e.ill));
`endif
      end
    end
  end

  task automatic waitDrain();
    int guard = 0;
    while ((q32.size() != 0 || q64.size() != 0) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("drain queue empty", 64'(q32.size() + q64.size()), 64'(0));
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset out_valid", 64'(out_valid), 64'(0));
    checkOutput("reset in_ready", 64'(in_ready), 64'(1));
    checkOutput("reset out_imm", 64'(out_imm), 64'(0));
    checkOutput("reset out_target", 64'(out_target), 64'(0));
    checkOutput("reset out_fmt", 64'(out_fmt), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    out_ready = 1'b1;
    applyStimulus(0, 32'hFFF00093, 32'h100, 64'hFFFFFFFF, 3'd1, 32'h000000FF, 1'b0);
    checkOutput("latency out_valid", 64'(out_valid), 64'(1));
    applyStimulus(0, 32'hFE000EE3, 32'h200, 64'hFFFFFFFC, 3'd3, 32'h000001FC, 1'b0);
    applyStimulus(0, 32'h123450B7, 32'h300, 64'h12345000, 3'd4, 32'h12345300, 1'b0);
    applyStimulus(0, 32'h00309093, 32'h400, 64'h3, 3'd6, 32'h403, 1'b0);
    applyStimulus(0, 32'h4030D093, 32'h404, 64'h3, 3'd6, 32'h407, 1'b0);
    applyStimulus(0, 32'hFE112E23, 32'h500, 64'hFFFFFFFC, 3'd2, 32'h4FC, 1'b0);
    applyStimulus(0, 32'h0080006F, 32'h600, 64'h8, 3'd5, 32'h608, 1'b0);
    applyStimulus(0, 32'hFF9FF06F, 32'h4, 64'hFFFFFFF8, 3'd5, 32'hFFFFFFFC, 1'b0);
    applyStimulus(0, 32'hFFFFF097, 32'h10, 64'hFFFFF000, 3'd4, 32'hFFFFF010, 1'b0);
    applyStimulus(0, 32'h002081B3, 32'h700, 64'h0, 3'd0, 32'h700, 1'b0);
    applyStimulus(0, 32'h00008067, 32'h800, 64'h0, 3'd1, 32'h800, 1'b0);
    applyStimulus(0, 32'h00000013, 32'h900, 64'h0, 3'd1, 32'h900, 1'b0);
    applyStimulus(0, 32'h0000007F, 32'h904, 64'h0, 3'd0, 32'h904, 1'b1);
    applyStimulus(0, 32'h00000001, 32'h908, 64'h0, 3'd0, 32'h908, 1'b1);
    waitDrain();

    // Backpressure: five back-to-back instructions against a stalled consumer.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          applyStimulus(0, 32'h00100093 + (i << 20), 32'h1000 + 4 * i,
                        64'(i + 1), 3'd1, 32'h1000 + 5 * i + 1, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("bp in_ready low", 64'(in_ready), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
          checkOutput("bp no gap", 64'(out_valid), 64'(1));
          @(posedge clk); #1;
        end
      end
    join
    waitDrain();

    // Flush with both entries occupied and a fresh input offered.
    out_ready = 1'b0;
    applyStimulus(0, 32'h00500093, 32'h2000, 64'h5, 3'd1, 32'h2005, 1'b0);
    applyStimulus(0, 32'h00600093, 32'h2004, 64'h6, 3'd1, 32'h200A, 1'b0);
    in_valid = 1'b1; in_instr = 32'h00700093; in_pc = 32'h2008; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    q32.delete();
    checkOutput("flush out_valid", 64'(out_valid), 64'(0));
    checkOutput("flush in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    applyStimulus(0, 32'h00800093, 32'h3000, 64'h8, 3'd1, 32'h3008, 1'b0);
    waitDrain();

    // Asynchronous reset pulse with a result pending.
    out_ready = 1'b0;
    applyStimulus(0, 32'hFFF00093, 32'h4000, 64'hFFFFFFFF, 3'd1, 32'h3FFF, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    q32.delete();
    checkOutput("async rst out_valid", 64'(out_valid), 64'(0));
    checkOutput("async rst in_ready", 64'(in_ready), 64'(1));
    checkOutput("async rst out_imm", 64'(out_imm), 64'(0));
    checkOutput("async rst out_instr", 64'(out_instr), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;

    applyStimulus(1, 32'h800000B7, 32'h1000, 64'hFFFFFFFF80000000, 3'd4, 32'h80001000, 1'b0);
    applyStimulus(1, 32'h02309093, 32'h2000, 64'd35, 3'd6, 32'h2023, 1'b0);
    applyStimulus(1, 32'hFFF00093, 32'h100, 64'hFFFFFFFFFFFFFFFF, 3'd1, 32'hFF, 1'b0);
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
